// File: rtl/shared_reg_arbiter_if.sv
// Write-request bus between datapath requesters and the shared-register arbiter.
// The master modport drives requests; the slave modport is the arbiter side.
interface shared_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  reg_en;
  logic [WIDTH-1:0]      reg_d;
  logic [2:0]            last_owner;
  logic [CNTW-1:0]       wr_cnt;

  modport master (
    output req, wdata,
    input  gnt, ack, reg_en, reg_d,
    input  last_owner, wr_cnt
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, reg_en, reg_d,
    output last_owner, wr_cnt
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared enabled register.
// Alternates IDLE (arbitrate) and WRITE (enable + ack) cycles.
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q;
  logic [2:0]       win_q;
  logic [2:0]       last_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  ack_q;
  logic [WIDTH-1:0] reg_d_q;
  logic [CNTW-1:0]  cnt_q;

  logic [7:0]       req8;
  logic [3:0]       j_c;
  logic [2:0]       win_c;
  logic             found_c;
  logic [NREQ-1:0]  oh_c;
  logic             any_req;
  logic             reg_en_c;
  logic [NREQ-1:0]  ack_c;

  assign req8    = 8'(bus.req);
  assign any_req = |bus.req;

  // Scan from ptr upward, wrapping at NREQ
  always_comb begin
    j_c     = 4'd0;
    win_c   = ptr_q;
    found_c = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j_c = {1'b0, ptr_q} + 4'(k);
      if (j_c >= 4'(NREQ)) j_c = j_c - 4'(NREQ);
      if (!found_c && req8[j_c[2:0]]) begin
        found_c = 1'b1;
        win_c   = j_c[2:0];
      end
    end
  end

  assign oh_c = NREQ'(1) << win_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_en_c = (state_q == WRITE) && !reset;
    ack_c    = reset ? '0 : ack_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      win_q   <= '0;
      last_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      reg_d_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == IDLE && any_req) begin
      win_q   <= win_c;
      gnt_q   <= oh_c;
      ack_q   <= oh_c;
      reg_d_q <= bus.wdata[win_c*WIDTH +: WIDTH];
    end else if (state_q == WRITE) begin
      ptr_q  <= (win_q == 3'(NREQ-1)) ? 3'd0 : win_q + 3'd1;
      last_q <= win_q;
      cnt_q  <= cnt_q + 1'b1;
      gnt_q  <= '0;
      ack_q  <= '0;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.ack        = ack_c;
  assign bus.reg_en     = reg_en_c;
  assign bus.reg_d      = reg_d_q;
  assign bus.last_owner = last_q;
  assign bus.wr_cnt     = cnt_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios then random
// requesters, all checked against a cycle-level reference model.
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.NREQ(N), .WIDTH(W), .CNTW(C)) bus ();

  shared_reg_arbiter #(.NREQ(N), .WIDTH(W), .CNTW(C)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [N-1:0] rq;
  logic [W-1:0] wd [N];
  logic [N-1:0] acked;

  bit           m_busy;
  int           m_win, m_ptr, m_last, m_cnt;
  logic [W-1:0] m_regd;
  int           order[$];

  task automatic drive();
    bus.req = rq;
    for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = wd[i];
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the intended behaviour, using inputs as seen at it.
  task automatic model_edge();
    bit found;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_last = 0; m_cnt = 0; m_regd = '0;
    end else if (m_busy) begin
      m_ptr  = (m_win + 1) % N;
      m_last = m_win;
      m_cnt  = (m_cnt + 1) % (1 << C);
      m_busy = 0;
    end else if (bus.req != 0) begin
      found = 0;
      for (int k = 0; k < N; k++)
        if (!found && bus.req[(m_ptr + k) % N]) begin
          found = 1;
          m_win = (m_ptr + k) % N;
        end
      m_regd = bus.wdata[m_win*W +: W];
      m_busy = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check(string tag);
    logic [N-1:0] eg, ea;
    logic         ee;
    #1;
    eg = m_busy ? (N'(1) << m_win) : '0;
    ee = m_busy && !rst;
    ea = ee ? eg : '0;
    chk({tag, ".gnt"},    64'(bus.gnt),        64'(eg));
    chk({tag, ".ack"},    64'(bus.ack),        64'(ea));
    chk({tag, ".reg_en"}, 64'(bus.reg_en),     64'(ee));
    chk({tag, ".wr_cnt"}, 64'(bus.wr_cnt),     64'(m_cnt));
    chk({tag, ".last"},   64'(bus.last_owner), 64'(m_last));
    chk({tag, ".onehot"}, 64'($countones(bus.gnt) <= 1), 64'(1));
    if (m_busy)
      chk({tag, ".reg_d"}, 64'(bus.reg_d), 64'(m_regd));
  endtask

  initial begin
    rq = '1;
    acked = '0;
    for (int i = 0; i < N; i++) wd[i] = 32'h1000_0000 + i;
    drive();

    rst = 1'b1;
    step(); check("rst0");
    step(); check("rst1");

    rst = 1'b0;
    rq = 4'b0100;
    wd[2] = 32'hDEADBEEF;
    drive();
    step(); check("single.w");
    chk("single.gnt", 64'(bus.gnt), 64'h4);
    chk("single.d", 64'(bus.reg_d), 64'hDEADBEEF);
    step();
    rq = '0; drive();
    check("single.i");
    chk("single.last", 64'(bus.last_owner), 64'd2);
    chk("single.cnt", 64'(bus.wr_cnt), 64'd1);

    rst = 1'b1; drive();
    step(); check("rst2");
    rst = 1'b0;
    rq = 4'b1111;
    for (int i = 0; i < N; i++) wd[i] = $urandom;
    drive();
    for (int c = 0; c < 12; c++) begin
      step(); check("fair");
      if (bus.gnt != 0) order.push_back($clog2(bus.gnt));
    end
    chk("fair.n", 64'(order.size()), 64'd6);
    for (int i = 0; i < order.size() && i < 6; i++)
      chk("fair.ord", 64'(order[i]), 64'(i % N));
    chk("fair.cnt", 64'(bus.wr_cnt), 64'd6);

    step(); check("skip.w2");
    step(); check("skip.i2");
    step(); check("skip.w3");
    chk("skip.g3", 64'(bus.gnt), 64'h8);
    step();
    rq = 4'b0011; drive();
    check("skip.i3");
    step(); check("skip.w0");
    chk("skip.g0", 64'(bus.gnt), 64'h1);
    step(); check("skip.i0");
    step(); check("skip.w1");
    chk("skip.g1", 64'(bus.gnt), 64'h2);
    step(); check("skip.end");

    rst = 1'b1; rq = '0; drive();
    step(); check("rst3");
    rst = 1'b0;
    rq = 4'b0010; drive();
    step(); check("mid.w");
    rst = 1'b1;
    check("mid.rst");
    chk("mid.en", 64'(bus.reg_en), 64'd0);
    chk("mid.ack", 64'(bus.ack), 64'd0);
    step(); check("mid.clr");
    rst = 1'b0;
    step(); check("mid.g");
    chk("mid.g1", 64'(bus.gnt), 64'h2);
    step(); check("mid.done");
    chk("mid.cnt", 64'(bus.wr_cnt), 64'd1);

    rst = 1'b1; drive();
    step(); check("rst4");
    rst = 1'b0;
    rq = 4'b0001; drive();
    for (int c = 0; c < 32; c++) begin
      step(); check("wrap");
      if (c == 29) chk("wrap.15", 64'(bus.wr_cnt), 64'd15);
    end
    chk("wrap.0", 64'(bus.wr_cnt), 64'd0);

    rq = '0; acked = '0; drive();
    step(); check("rnd.start");
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (m_busy && m_win == i) begin
          acked[i] = 1'b1;
        end else if (acked[i]) begin
          acked[i] = 1'b0;
          if ($urandom_range(1, 0) == 0) rq[i] = 1'b0;
          else wd[i] = $urandom;
        end else if (!rq[i] && $urandom_range(2, 0) == 0) begin
          rq[i] = 1'b1;
          wd[i] = $urandom;
        end
      end
      drive();
      check("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
